// File: rtl/axil_regbank_pkg.sv
// Shared types and constants for the axil_regbank AXI4-Lite register bank.
// Used by axil_regbank and, when AXIL_REGBANK_IRQ_EN is defined, axil_regbank_irq.
package axil_regbank_pkg;

    typedef logic [1:0] resp_t;
    localparam resp_t OKAY   = 2'b00;
    localparam resp_t SLVERR = 2'b10;

    typedef enum logic [2:0] {
        WIdle,
        WHaveA,
        WHaveD,
        WCommit,
        WResp
    } wr_state_e;

    typedef enum logic {
        RIdle,
        RResp
    } rd_state_e;

    // Interrupt registers sit directly after the last user register.
    localparam int unsigned ISR_OFS = 0;
    localparam int unsigned IER_OFS = 1;

    function automatic int unsigned addr_lsb(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axil_regbank_irq.sv
// Interrupt block for axil_regbank: rising-edge capture into a sticky write-1-to-clear ISR,
// a read/write IER and a registered irq = |(ISR & IER).
module axil_regbank_irq
    import axil_regbank_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_IRQ      = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [N_IRQ-1:0]        irq_src_i,
    input  logic                    isr_we_i,
    input  logic                    ier_we_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    output logic [DATA_WIDTH-1:0]   isr_o,
    output logic [DATA_WIDTH-1:0]   ier_o,
    output logic                    irq_o
);

    logic [N_IRQ-1:0] src_d, src_q;
    logic [N_IRQ-1:0] isr_d, isr_q;
    logic [N_IRQ-1:0] ier_d, ier_q;
    logic [N_IRQ-1:0] clr;
    logic             irq_d, irq_q;
    logic             unused_ok;

    assign unused_ok = ^{wdata_i, wstrb_i};

    always_comb begin
        src_d = irq_src_i;
        clr   = '0;
        ier_d = ier_q;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            clr[i] = isr_we_i && wstrb_i[i/8] && wdata_i[i];
            if (ier_we_i && wstrb_i[i/8]) begin
                ier_d[i] = wdata_i[i];
            end
        end
        // The new edge is OR-ed in after the clear so a simultaneous set wins.
        isr_d = (isr_q & ~clr) | (irq_src_i & ~src_q);
        irq_d = |(isr_q & ier_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q <= '0;
            isr_q <= '0;
            ier_q <= '0;
            irq_q <= 1'b0;
        end else begin
            src_q <= src_d;
            isr_q <= isr_d;
            ier_q <= ier_d;
            irq_q <= irq_d;
        end
    end

    always_comb begin
        isr_o              = '0;
        ier_o              = '0;
        isr_o[N_IRQ-1:0]   = isr_q;
        ier_o[N_IRQ-1:0]   = ier_q;
    end

    assign irq_o = irq_q;

endmodule

// File: rtl/axil_regbank.sv
// Parametrised AXI4-Lite slave register bank with byte strobes, read-only status registers,
// per-register write pulses and SLVERR. Define AXIL_REGBANK_IRQ_EN to add ISR/IER and irq.
module axil_regbank
    import axil_regbank_pkg::*;
#(
    parameter int unsigned       DATA_WIDTH = 32,
    parameter int unsigned       ADDR_WIDTH = 6,
    parameter int unsigned       N_REGS     = 8,
    parameter logic [N_REGS-1:0] RO_MASK    = {N_REGS{1'b0}}
`ifdef AXIL_REGBANK_IRQ_EN
    ,
    parameter int unsigned       N_IRQ      = 8
`endif
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    input  logic [ADDR_WIDTH-1:0]        AWADDR,
    input  logic [2:0]                   AWPROT,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    input  logic [DATA_WIDTH-1:0]        WDATA,
    input  logic [DATA_WIDTH/8-1:0]      WSTRB,
    input  logic                         WVALID,
    output logic                         WREADY,
    output logic [1:0]                   BRESP,
    output logic                         BVALID,
    input  logic                         BREADY,
    input  logic [ADDR_WIDTH-1:0]        ARADDR,
    input  logic [2:0]                   ARPROT,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    output logic [DATA_WIDTH-1:0]        RDATA,
    output logic [1:0]                   RRESP,
    output logic                         RVALID,
    input  logic                         RREADY,
    output logic [N_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [N_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [N_REGS-1:0]            wr_pulse
`ifdef AXIL_REGBANK_IRQ_EN
    ,
    input  logic [N_IRQ-1:0]             irq_src,
    output logic                         irq
`endif
);

    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB = addr_lsb(DATA_WIDTH);
    localparam int unsigned IDX_W    = ADDR_WIDTH - ADDR_LSB;

    wr_state_e             wr_state_d, wr_state_q;
    rd_state_e             rd_state_d, rd_state_q;
    logic [IDX_W-1:0]      aw_idx_d, aw_idx_q;
    logic [DATA_WIDTH-1:0] wdata_d, wdata_q;
    logic [STRB_W-1:0]     wstrb_d, wstrb_q;
    resp_t                 bresp_d, bresp_q;
    logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
    resp_t                 rresp_d, rresp_q;
    logic [DATA_WIDTH-1:0] regs_d [N_REGS];
    logic [DATA_WIDTH-1:0] regs_q [N_REGS];
    // Keeps the READY outputs low until the first clock edge after reset release.
    logic                  out_en_q;

    logic [IDX_W-1:0]      ar_idx;
    logic [N_REGS-1:0]     wr_hit;
    logic                  wr_ok;
    logic                  commit;
    logic [DATA_WIDTH-1:0] rd_val;
    resp_t                 rd_resp;
    logic                  unused_ok;

    assign unused_ok = ^{AWPROT, ARPROT, AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0], reg_in};
    assign commit    = (wr_state_q == WCommit);
    assign ar_idx    = ARADDR[ADDR_WIDTH-1:ADDR_LSB];

    always_comb begin
        wr_hit = '0;
        for (int unsigned i = 0; i < N_REGS; i++) begin
            wr_hit[i] = (32'(aw_idx_q) == i) && !RO_MASK[i];
        end
    end

`ifdef AXIL_REGBANK_IRQ_EN
    logic                  isr_sel, ier_sel;
    logic [DATA_WIDTH-1:0] isr_val, ier_val;

    assign isr_sel = (32'(aw_idx_q) == N_REGS + ISR_OFS);
    assign ier_sel = (32'(aw_idx_q) == N_REGS + IER_OFS);
    assign wr_ok   = (|wr_hit) || isr_sel || ier_sel;

    axil_regbank_irq #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_IRQ      (N_IRQ)
    ) u_irq (
        .clk_i      (ACLK),
        .rst_ni     (ARESETN),
        .irq_src_i  (irq_src),
        .isr_we_i   (commit && isr_sel),
        .ier_we_i   (commit && ier_sel),
        .wdata_i    (wdata_q),
        .wstrb_i    (wstrb_q),
        .isr_o      (isr_val),
        .ier_o      (ier_val),
        .irq_o      (irq)
    );
`else
    assign wr_ok = |wr_hit;
`endif

    // Write channel FSM.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_idx_d   = aw_idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        AWREADY    = 1'b0;
        WREADY     = 1'b0;
        case (wr_state_q)
            WIdle: begin
                AWREADY = out_en_q;
                WREADY  = out_en_q;
                if (out_en_q && AWVALID) begin
                    aw_idx_d = AWADDR[ADDR_WIDTH-1:ADDR_LSB];
                end
                if (out_en_q && WVALID) begin
                    wdata_d = WDATA;
                    wstrb_d = WSTRB;
                end
                if (out_en_q && AWVALID && WVALID) begin
                    wr_state_d = WCommit;
                end else if (out_en_q && AWVALID) begin
                    wr_state_d = WHaveA;
                end else if (out_en_q && WVALID) begin
                    wr_state_d = WHaveD;
                end
            end
            WHaveA: begin
                WREADY = 1'b1;
                if (WVALID) begin
                    wdata_d    = WDATA;
                    wstrb_d    = WSTRB;
                    wr_state_d = WCommit;
                end
            end
            WHaveD: begin
                AWREADY = 1'b1;
                if (AWVALID) begin
                    aw_idx_d   = AWADDR[ADDR_WIDTH-1:ADDR_LSB];
                    wr_state_d = WCommit;
                end
            end
            WCommit: begin
                bresp_d    = wr_ok ? OKAY : SLVERR;
                wr_state_d = WResp;
            end
            WResp: begin
                if (BREADY) begin
                    wr_state_d = WIdle;
                end
            end
            default: wr_state_d = WIdle;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < N_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (commit && wr_hit[i]) begin
                for (int unsigned b = 0; b < STRB_W; b++) begin
                    if (wstrb_q[b]) begin
                        regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read data mux; RO registers mirror reg_in as seen in the handshake cycle.
    always_comb begin
        rd_val  = '0;
        rd_resp = SLVERR;
        for (int unsigned i = 0; i < N_REGS; i++) begin
            if (32'(ar_idx) == i) begin
                rd_resp = OKAY;
                rd_val  = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
            end
        end
`ifdef AXIL_REGBANK_IRQ_EN
        if (32'(ar_idx) == N_REGS + ISR_OFS) begin
            rd_resp = OKAY;
            rd_val  = isr_val;
        end
        if (32'(ar_idx) == N_REGS + IER_OFS) begin
            rd_resp = OKAY;
            rd_val  = ier_val;
        end
`endif
    end

    // Read channel FSM.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        ARREADY    = 1'b0;
        case (rd_state_q)
            RIdle: begin
                ARREADY = out_en_q;
                if (out_en_q && ARVALID) begin
                    rdata_d    = rd_val;
                    rresp_d    = rd_resp;
                    rd_state_d = RResp;
                end
            end
            RResp: begin
                if (RREADY) begin
                    rd_state_d = RIdle;
                end
            end
            default: rd_state_d = RIdle;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            out_en_q   <= 1'b0;
            wr_state_q <= WIdle;
            rd_state_q <= RIdle;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= OKAY;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
            for (int unsigned i = 0; i < N_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            out_en_q   <= 1'b1;
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            aw_idx_q   <= aw_idx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            for (int unsigned i = 0; i < N_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        reg_out = '0;
        for (int unsigned i = 0; i < N_REGS; i++) begin
            reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        end
    end

    assign wr_pulse = commit ? wr_hit : '0;
    assign BVALID   = (wr_state_q == WResp);
    assign BRESP    = bresp_q;
    assign RVALID   = (rd_state_q == RResp);
    assign RDATA    = rdata_q;
    assign RRESP    = rresp_q;

endmodule

// File: tb/tb_axil_regbank.sv
// Directed self-checking bench for axil_regbank (32-bit data, 8 registers, register 2 read-only).
// Also covers the interrupt registers when AXIL_REGBANK_IRQ_EN is defined.
module tb_axil_regbank;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NR = 8;
    localparam logic [1:0] R_OK  = 2'b00;
    localparam logic [1:0] R_ERR = 2'b10;

    logic             ACLK = 1'b0;
    logic             ARESETN;
    logic [AW-1:0]    AWADDR, ARADDR;
    logic [2:0]       AWPROT, ARPROT;
    logic             AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic             ARVALID, ARREADY, RVALID, RREADY;
    logic [DW-1:0]    WDATA, RDATA;
    logic [DW/8-1:0]  WSTRB;
    logic [1:0]       BRESP, RRESP;
    logic [NR*DW-1:0] reg_out, reg_in;
    logic [NR-1:0]    wr_pulse;
`ifdef AXIL_REGBANK_IRQ_EN
    logic [7:0]       irq_src;
    logic             irq;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_cnt [NR] = '{default: 0};

    always #5 ACLK = ~ACLK;

    axil_regbank #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .N_REGS     (NR),
        .RO_MASK    (8'b0000_0100)
    ) dut (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .AWADDR   (AWADDR),
        .AWPROT   (AWPROT),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BRESP    (BRESP),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .ARADDR   (ARADDR),
        .ARPROT   (ARPROT),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .RDATA    (RDATA),
        .RRESP    (RRESP),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .reg_out  (reg_out),
        .reg_in   (reg_in),
        .wr_pulse (wr_pulse)
`ifdef AXIL_REGBANK_IRQ_EN
        ,
        .irq_src  (irq_src),
        .irq      (irq)
`endif
    );

    // Counts cycles each write pulse is high.
    always @(negedge ACLK) begin
        for (int i = 0; i < NR; i++) begin
            if (wr_pulse[i]) pulse_cnt[i] = pulse_cnt[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues AW/W with independent start delays; holds BREADY low for 'hold' cycles after BVALID.
    task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int hold, output logic [1:0] resp, output int lat);
        bit aw_done = 0;
        bit w_done  = 0;
        int cyc     = 0;
        lat  = 0;
        resp = 2'b11;
        while (!(aw_done && w_done) && cyc < 100) begin
            if (!aw_done && cyc >= aw_dly) begin
                AWADDR  = addr;
                AWVALID = 1'b1;
            end
            if (!w_done && cyc >= w_dly) begin
                WDATA  = data;
                WSTRB  = strb;
                WVALID = 1'b1;
            end
            @(negedge ACLK);
            if (AWVALID && AWREADY) aw_done = 1;
            if (WVALID && WREADY) w_done = 1;
            @(posedge ACLK);
            #1;
            if (aw_done) AWVALID = 1'b0;
            if (w_done) WVALID = 1'b0;
            cyc++;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        check("wr_handshake", {63'b0, aw_done && w_done}, 64'd1);
        lat = 1;
        while (lat < 20) begin
            @(negedge ACLK);
            if (BVALID) break;
            lat++;
        end
        check("bvalid_seen", {63'b0, BVALID}, 64'd1);
        resp = BRESP;
        for (int k = 0; k < hold; k++) begin
            @(posedge ACLK);
            @(negedge ACLK);
            check("bvalid_hold", {63'b0, BVALID}, 64'd1);
            check("bresp_stable", {62'b0, BRESP}, {62'b0, resp});
            check("awready_blocked", {63'b0, AWREADY}, 64'd0);
        end
        BREADY = 1'b1;
        @(posedge ACLK);
        #1;
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                            output logic [1:0] resp);
        int cyc = 0;
        ARADDR  = addr;
        ARVALID = 1'b1;
        @(negedge ACLK);
        while (!ARREADY && cyc < 50) begin
            @(negedge ACLK);
            cyc++;
        end
        @(posedge ACLK);
        #1;
        ARVALID = 1'b0;
        check("rvalid_1cyc", {63'b0, RVALID}, 64'd1);
        cyc = 0;
        while (!RVALID && cyc < 50) begin
            @(posedge ACLK);
            #1;
            cyc++;
        end
        @(negedge ACLK);
        data   = RDATA;
        resp   = RRESP;
        RREADY = 1'b1;
        @(posedge ACLK);
        #1;
        RREADY = 1'b0;
    endtask

    logic [AW-1:0] t1_addr [4] = '{6'h00, 6'h04, 6'h0C, 6'h10};
    logic [DW-1:0] t1_data [4] = '{32'h1, 32'h2, 32'h3, 32'h4};

    initial begin
        logic [1:0]    resp;
        logic [DW-1:0] rd;
        int            lat;
        int            p0;

        ARESETN = 1'b0;
        AWADDR  = '0;
        ARADDR  = '0;
        AWPROT  = '0;
        ARPROT  = '0;
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        ARVALID = 1'b0;
        BREADY  = 1'b0;
        RREADY  = 1'b0;
        WDATA   = '0;
        WSTRB   = '0;
        reg_in  = '0;
        for (int i = 0; i < NR; i++) reg_in[i*DW +: DW] = 32'h5A5A_0000 + i;
        reg_in[2*DW +: DW] = 32'hCAFE_F00D;
`ifdef AXIL_REGBANK_IRQ_EN
        irq_src = '0;
`endif

        // Reset state
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_awready", {63'b0, AWREADY}, 64'd0);
        check("rst_wready", {63'b0, WREADY}, 64'd0);
        check("rst_arready", {63'b0, ARREADY}, 64'd0);
        check("rst_bvalid", {63'b0, BVALID}, 64'd0);
        check("rst_rvalid", {63'b0, RVALID}, 64'd0);
        check("rst_resps", {60'b0, BRESP, RRESP}, 64'd0);
        check("rst_rdata", {32'b0, RDATA}, 64'd0);
        check("rst_wr_pulse", {56'b0, wr_pulse}, 64'd0);
        check("rst_reg_out", {63'b0, reg_out == '0}, 64'd1);
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;

        // Basic writes and readback
        for (int i = 0; i < 4; i++) begin
            p0 = pulse_cnt[t1_addr[i] >> 2];
            axi_write(t1_addr[i], t1_data[i], 4'hF, 0, 0, 0, resp, lat);
            check("basic_bresp", {62'b0, resp}, {62'b0, R_OK});
            check("basic_pulse", 64'(pulse_cnt[t1_addr[i] >> 2] - p0), 64'd1);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(t1_addr[i], rd, resp);
            check("basic_rdata", {32'b0, rd}, {32'b0, t1_data[i]});
            check("basic_rresp", {62'b0, resp}, {62'b0, R_OK});
        end
        check("reg_out_slice3", {32'b0, reg_out[3*DW +: DW]}, 64'd3);

        // Read-only register 2
        axi_write(6'h08, 32'h1234_5678, 4'hF, 0, 0, 0, resp, lat);
        check("ro_bresp", {62'b0, resp}, {62'b0, R_ERR});
        check("ro_no_pulse", 64'(pulse_cnt[2]), 64'd0);
        check("ro_reg_out", {32'b0, reg_out[2*DW +: DW]}, 64'd0);
        axi_read(6'h08, rd, resp);
        check("ro_rdata", {32'b0, rd}, 64'hCAFE_F00D);
        check("ro_rresp", {62'b0, resp}, {62'b0, R_OK});

        // Byte strobes and the WSTRB=0 no-op
        axi_write(6'h00, 32'h1122_3344, 4'hF, 0, 0, 0, resp, lat);
        axi_write(6'h00, 32'hAABB_CCDD, 4'b0101, 0, 0, 0, resp, lat);
        axi_read(6'h00, rd, resp);
        check("strb_0101", {32'b0, rd}, 64'h11BB_33DD);
        p0 = pulse_cnt[0];
        axi_write(6'h00, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0, resp, lat);
        check("strb0_bresp", {62'b0, resp}, {62'b0, R_OK});
        check("strb0_pulse", 64'(pulse_cnt[0] - p0), 64'd1);
        axi_read(6'h00, rd, resp);
        check("strb0_unchanged", {32'b0, rd}, 64'h11BB_33DD);

        // AW/W ordering, latency and B-channel backpressure
        p0 = pulse_cnt[5];
        axi_write(6'h14, 32'h55, 4'hF, 0, 0, 10, resp, lat);
        check("same_cyc_lat", 64'(lat), 64'd2);
        check("same_cyc_pulse", 64'(pulse_cnt[5] - p0), 64'd1);
        p0 = pulse_cnt[6];
        axi_write(6'h18, 32'h66, 4'hF, 3, 0, 0, resp, lat);
        check("w_first_lat", 64'(lat), 64'd2);
        check("w_first_pulse", 64'(pulse_cnt[6] - p0), 64'd1);
        axi_write(6'h1C, 32'h77, 4'hF, 0, 2, 0, resp, lat);
        check("aw_first_lat", 64'(lat), 64'd2);
        axi_read(6'h14, rd, resp);
        check("same_cyc_rd", {32'b0, rd}, 64'h55);
        axi_read(6'h18, rd, resp);
        check("w_first_rd", {32'b0, rd}, 64'h66);
        axi_read(6'h1C, rd, resp);
        check("aw_first_rd", {32'b0, rd}, 64'h77);

        // Read handshake in the commit cycle sees the old value
        AWADDR  = 6'h00;
        WDATA   = 32'h1234_5678;
        WSTRB   = 4'hF;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        @(posedge ACLK);
        #1;
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        ARADDR  = 6'h00;
        ARVALID = 1'b1;
        check("commit_pulse", {63'b0, wr_pulse[0]}, 64'd1);
        @(posedge ACLK);
        #1;
        ARVALID = 1'b0;
        check("rd_in_commit", {32'b0, RDATA}, 64'h11BB_33DD);
        check("bvalid_after_commit", {63'b0, BVALID}, 64'd1);
        RREADY = 1'b1;
        BREADY = 1'b1;
        @(posedge ACLK);
        #1;
        RREADY = 1'b0;
        BREADY = 1'b0;
        axi_read(6'h00, rd, resp);
        check("rd_after_commit", {32'b0, rd}, 64'h1234_5678);

        // Out-of-range accesses
        axi_read(6'h3C, rd, resp);
        check("oor_rdata", {32'b0, rd}, 64'd0);
        check("oor_rresp", {62'b0, resp}, {62'b0, R_ERR});
        axi_write(6'h3C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp, lat);
        check("oor_bresp", {62'b0, resp}, {62'b0, R_ERR});
`ifndef AXIL_REGBANK_IRQ_EN
        axi_read(6'h20, rd, resp);
        check("idx_nregs_rresp", {62'b0, resp}, {62'b0, R_ERR});
        check("idx_nregs_rdata", {32'b0, rd}, 64'd0);
`endif

        // Reset with BVALID pending
        AWADDR  = 6'h04;
        WDATA   = 32'hDEAD;
        WSTRB   = 4'hF;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        @(posedge ACLK);
        #1;
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        check("pre_rst_bvalid", {63'b0, BVALID}, 64'd1);
        ARESETN = 1'b0;
        #1;
        check("async_bvalid_drop", {63'b0, BVALID}, 64'd0);
        check("async_regs_clear", {63'b0, reg_out == '0}, 64'd1);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        axi_write(6'h04, 32'h99, 4'hF, 0, 0, 0, resp, lat);
        check("post_rst_bresp", {62'b0, resp}, {62'b0, R_OK});
        check("post_rst_lat", 64'(lat), 64'd2);
        axi_read(6'h04, rd, resp);
        check("post_rst_rd", {32'b0, rd}, 64'h99);
        axi_read(6'h00, rd, resp);
        check("post_rst_reg0", {32'b0, rd}, 64'd0);

`ifdef AXIL_REGBANK_IRQ_EN
        // Interrupt registers: ISR at 0x20, IER at 0x24
        axi_write(6'h24, 32'h1, 4'hF, 0, 0, 0, resp, lat);
        check("ier_bresp", {62'b0, resp}, {62'b0, R_OK});
        irq_src[0] = 1'b1;
        @(posedge ACLK);
        #1;
        check("irq_lags_isr", {63'b0, irq}, 64'd0);
        @(posedge ACLK);
        #1;
        check("irq_set", {63'b0, irq}, 64'd1);
        irq_src[0] = 1'b0;
        axi_read(6'h20, rd, resp);
        check("isr_rd", {32'b0, rd}, 64'h1);
        axi_write(6'h20, 32'h1, 4'hF, 0, 0, 0, resp, lat);
        check("isr_clr_irq", {63'b0, irq}, 64'd0);
        axi_read(6'h20, rd, resp);
        check("isr_cleared", {32'b0, rd}, 64'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
